// File: rtl/rf_pkg.sv
// Shared types and default constants for the multiport register file.
package rf_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam logic [31:0] SP_INIT_DEF = 32'hF00;
    localparam logic [31:0] GP_INIT_DEF = 32'h100;

    // Reset image: entry 2 gets the stack pointer, entry 3 the global pointer, the rest zero.
    function automatic logic [31:0] init_value(input logic [31:0] idx,
                                               input logic [31:0] sp,
                                               input logic [31:0] gp);
        logic [31:0] val;
        val = 32'h0;
        if (idx == 32'd2) begin
            val = sp;
        end else if (idx == 32'd3) begin
            val = gp;
        end
        return val;
    endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset sweep that writes the reset image into every entry, one per cycle.
// state | meaning
// INIT  | sweeping entries 0..DEPTH-1, accesses blocked
// RUN   | image written, register file ready
module rf_init_seq
    import rf_pkg::*;
#(
    parameter int          DWIDTH  = 32,
    parameter int          DEPTH   = 32,
    parameter int          AWIDTH  = $clog2(DEPTH),
    parameter logic [31:0] SP_INIT = SP_INIT_DEF,
    parameter logic [31:0] GP_INIT = GP_INIT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              ready,
    output logic              init_we,
    output logic [AWIDTH-1:0] init_addr,
    output logic [DWIDTH-1:0] init_data
);

    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    rf_state_e         state, state_nxt;
    logic [AWIDTH-1:0] idx, idx_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= INIT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            INIT: begin
                idx_nxt = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // A reset cycle never writes, so the sweep only progresses with RST low.
    always_comb begin
        ready     = (state == RUN);
        init_we   = (state == INIT) && !RST;
        init_addr = idx;
        init_data = DWIDTH'(init_value(32'(idx), SP_INIT, GP_INIT));
    end

endmodule

// File: rtl/rf_multiport.sv
// Two-write, NRD-read register file with hardwired-zero entry 0 and a swept reset image.
// Define RF_BYPASS_EN to forward same-cycle committing write data to matching read ports.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int          DWIDTH  = 32,
    parameter int          DEPTH   = 32,
    parameter int          AWIDTH  = $clog2(DEPTH),
    parameter int          NRD     = 2,
    parameter logic [31:0] SP_INIT = SP_INIT_DEF,
    parameter logic [31:0] GP_INIT = GP_INIT_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WE0,
    input  logic                    WE1,
    input  logic [AWIDTH-1:0]       WA0,
    input  logic [AWIDTH-1:0]       WA1,
    input  logic [DWIDTH-1:0]       WD0,
    input  logic [DWIDTH-1:0]       WD1,
    input  logic [NRD*AWIDTH-1:0]   RA,
    output logic [NRD*DWIDTH-1:0]   RD,
    output logic                    READY,
    output logic                    ERR_COLL
);

    logic [DWIDTH-1:0] mem [DEPTH];

    logic              init_we;
    logic [AWIDTH-1:0] init_addr;
    logic [DWIDTH-1:0] init_data;

    logic wr_ok;
    logic commit0, commit1, coll;

    rf_init_seq #(
        .DWIDTH  (DWIDTH),
        .DEPTH   (DEPTH),
        .AWIDTH  (AWIDTH),
        .SP_INIT (SP_INIT),
        .GP_INIT (GP_INIT)
    ) u_init_seq (
        .CLK       (CLK),
        .RST       (RST),
        .ready     (READY),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // Port 1 wins a same-address collision; port 0's write is dropped, not merged.
    always_comb begin
        wr_ok   = READY && !RST;
        commit1 = wr_ok && WE1 && (WA1 != '0);
        coll    = wr_ok && WE0 && WE1 && (WA0 == WA1) && (WA0 != '0);
        commit0 = wr_ok && WE0 && (WA0 != '0) && !coll;
    end

    always_ff @(posedge CLK) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else begin
            if (commit0) begin
                mem[WA0] <= WD0;
            end
            if (commit1) begin
                mem[WA1] <= WD1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR_COLL <= 1'b0;
        end else begin
            ERR_COLL <= coll;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AWIDTH-1:0] ra_k;
        logic [DWIDTH-1:0] rd_k;

        assign ra_k = RA[k*AWIDTH +: AWIDTH];

        always_comb begin
            rd_k = '0;
            if (READY && (ra_k != '0)) begin
                rd_k = mem[ra_k];
`ifdef RF_BYPASS_EN
                if (commit1 && (WA1 == ra_k)) begin
                    rd_k = WD1;
                end else if (commit0 && (WA0 == ra_k)) begin
                    rd_k = WD0;
                end
`endif
            end
        end

        assign RD[k*DWIDTH +: DWIDTH] = rd_k;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed vector table, reset/init sequences and random traffic.
module tb_rf_multiport;

    localparam int DW  = 32;
    localparam int DEP = 32;
    localparam int AW  = 5;
    localparam int NR  = 2;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             WE0 = 1'b0, WE1 = 1'b0;
    logic [AW-1:0]    WA0 = '0, WA1 = '0;
    logic [DW-1:0]    WD0 = '0, WD1 = '0;
    logic [NR*AW-1:0] RA  = '0;
    logic [NR*DW-1:0] RD;
    logic             READY, ERR_COLL;

    always #5 CLK = ~CLK;

    rf_multiport #(
        .DWIDTH (DW),
        .DEPTH  (DEP),
        .AWIDTH (AW),
        .NRD    (NR)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .WE0      (WE0),
        .WE1      (WE1),
        .WA0      (WA0),
        .WA1      (WA1),
        .WD0      (WD0),
        .WD1      (WD1),
        .RA       (RA),
        .RD       (RD),
        .READY    (READY),
        .ERR_COLL (ERR_COLL)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: stored contents, readiness and the pending collision flag.
    logic [31:0] m_mem [DEP];
    bit          m_ready = 1'b0;
    int          m_cnt   = 0;
    bit          m_err   = 1'b0;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_err;
        string       name;
    } vec_t;

    vec_t tv [11];

    function automatic vec_t mk(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1, input logic ee,
                                input string nm);
        vec_t v;
        v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0;
        v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e0; v.e_rd1 = e1; v.e_err = ee;
        v.name = nm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        if (!m_ready || ra == 5'd0) return 32'h0;
        if (BYP && !RST) begin
            if (WE1 && WA1 == ra) return WD1;
            if (WE0 && WA0 == ra) return WD0;
        end
        return m_mem[ra];
    endfunction

    task automatic apply(input bit rst, input bit we0, input logic [4:0] wa0, input logic [31:0] wd0,
                         input bit we1, input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
        RST = rst; WE0 = we0; WA0 = wa0; WD0 = wd0;
        WE1 = we1; WA1 = wa1; WD1 = wd1;
        RA  = {ra1, ra0};
        #3;
        chk({tag, ".rd0"},   RD[31:0],  m_read(ra0));
        chk({tag, ".rd1"},   RD[63:32], m_read(ra1));
        chk({tag, ".ready"}, {31'b0, READY},    {31'b0, m_ready});
        chk({tag, ".err"},   {31'b0, ERR_COLL}, {31'b0, m_err});
    endtask

    task automatic edge_upd();
        @(posedge CLK);
        if (RST) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else if (!m_ready) begin
            m_err = 1'b0;
            m_cnt++;
            if (m_cnt == DEP) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEP; i++) m_mem[i] = 32'h0;
                m_mem[2] = 32'hF00;
                m_mem[3] = 32'h100;
            end
        end else begin
            m_err = WE0 && WE1 && (WA0 == WA1) && (WA0 != 5'd0);
            if (WE0 && WA0 != 5'd0 && !m_err) m_mem[WA0] = WD0;
            if (WE1 && WA1 != 5'd0)           m_mem[WA1] = WD1;
        end
        #1;
    endtask

    task automatic step(input bit rst, input bit we0, input logic [4:0] wa0, input logic [31:0] wd0,
                        input bit we1, input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic [4:0] ra0, input logic [4:0] ra1, input string tag);
        apply(rst, we0, wa0, wd0, we1, wa1, wd1, ra0, ra1, tag);
        edge_upd();
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEP; i++) m_mem[i] = 32'h0;

        tv[0]  = mk(0, 0, 0,            0, 0, 0,            2, 3, 32'hF00, 32'h100, 0, "init_vals");
        tv[1]  = mk(0, 0, 0,            0, 0, 0,            5, 0, 0, 0, 0, "x5_x0");
        tv[2]  = mk(1, 7, 32'hAAAA,     1, 7, 32'h5555,     7, 3, BYP ? 32'h5555 : 32'h0, 32'h100, 0, "coll_wr");
        tv[3]  = mk(0, 0, 0,            0, 0, 0,            7, 7, 32'h5555, 32'h5555, 1, "coll_pulse");
        tv[4]  = mk(0, 0, 0,            0, 0, 0,            7, 2, 32'h5555, 32'hF00, 0, "coll_clear");
        tv[5]  = mk(1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0, 0, 0, 0, "x0_wr");
        tv[6]  = mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0, 0, "x0_after");
        tv[7]  = mk(1, 4, 32'h1234,     0, 0, 0,            4, 4, BYP ? 32'h1234 : 32'h0, BYP ? 32'h1234 : 32'h0, 0, "byp_same");
        tv[8]  = mk(0, 0, 0,            0, 0, 0,            4, 0, 32'h1234, 0, 0, "byp_next");
        tv[9]  = mk(1, 8, 32'h11,       1, 9, 32'h22,       8, 9, BYP ? 32'h11 : 32'h0, BYP ? 32'h22 : 32'h0, 0, "dual_wr");
        tv[10] = mk(0, 0, 0,            0, 0, 0,            8, 9, 32'h11, 32'h22, 0, "dual_rd");

        // First edge gives the DUT a known state; checking starts afterwards.
        @(posedge CLK);
        #1;
        step(1, 0, 0, 0, 0, 0, 0, 2, 3, "rst0");
        step(1, 1, 5, 32'h77, 0, 0, 0, 2, 3, "rst1");

        n = 0;
        while (!READY && n < 40) begin
            step(0, 0, 0, 0, 0, 0, 0, 2, 3, "sweep");
            n++;
        end
        chk("init_latency", 32'(n), 32'd32);
        apply(0, 0, 0, 0, 0, 0, 0, 2, 3, "sweep_rd");
        chk("x2_init", RD[31:0], 32'hF00);
        chk("x3_init", RD[63:32], 32'h100);
        edge_upd();
        apply(0, 0, 0, 0, 0, 0, 0, 5, 0, "sweep_rd5");
        chk("x5_init", RD[31:0], 32'h0);
        edge_upd();

        for (int i = 0; i < 11; i++) begin
            apply(0, tv[i].we0, tv[i].wa0, tv[i].wd0, tv[i].we1, tv[i].wa1, tv[i].wd1,
                  tv[i].ra0, tv[i].ra1, tv[i].name);
            chk({tv[i].name, ".t_rd0"}, RD[31:0],  tv[i].e_rd0);
            chk({tv[i].name, ".t_rd1"}, RD[63:32], tv[i].e_rd1);
            chk({tv[i].name, ".t_err"}, {31'b0, ERR_COLL}, {31'b0, tv[i].e_err});
            edge_upd();
        end

        // Reset pulsed part-way through the sweep restarts it; writes in the window are lost.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_rst_a");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "mid_rst_b");
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 5, 2, "mid_sweep");
        step(1, 1, 5, 32'hDEAD, 0, 0, 0, 5, 2, "mid_pulse");
        n = 0;
        while (!READY && n < 40) begin
            step(0, 1, 5, 32'hDEAD, 1, 6, 32'hBEEF, 5, 6, "mid_wr");
            n++;
        end
        chk("mid_rst_latency", 32'(n), 32'd32);
        apply(0, 0, 0, 0, 0, 0, 0, 5, 6, "mid_rd");
        chk("mid_x5", RD[31:0], 32'h0);
        chk("mid_x6", RD[63:32], 32'h0);
        edge_upd();

        for (int it = 0; it < 600; it++) begin
            bit          r;
            logic [4:0]  a0, a1, r0, r1;
            r  = ($urandom_range(0, 99) == 0);
            a0 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a1 = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r0 = $urandom_range(0, 1) ? a0 : 5'($urandom_range(0, 31));
            r1 = $urandom_range(0, 1) ? a1 : 5'($urandom_range(0, 31));
            step(r, 1'($urandom_range(0, 1)), a0, $urandom,
                 1'($urandom_range(0, 1)), a1, $urandom, r0, r1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
